// File: rtl/pspin_cmd_responder.sv
// Cluster-side HPU command endpoint: round-robin intake, tag allocation, single-stage engine
// request register and tagged completion broadcast back to the issuing cores.
module pspin_cmd_responder #(
    parameter int unsigned NUM_HPUS         = 8,
    parameter int unsigned NUM_OUTSTANDING  = 8,
    parameter int unsigned CLUSTER_ID_WIDTH = 16,
    parameter int unsigned CORE_ID_WIDTH    = 16,
    parameter int unsigned LOCAL_ID_WIDTH   = 4,
    parameter int unsigned CMD_DATA_WIDTH   = 128,
    localparam int unsigned ID_W  = CLUSTER_ID_WIDTH + CORE_ID_WIDTH + LOCAL_ID_WIDTH,
    localparam int unsigned TAG_W = $clog2(NUM_OUTSTANDING)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NUM_HPUS-1:0]                      cmd_valid_i,
    output logic [NUM_HPUS-1:0]                      cmd_ready_o,
    input  logic [NUM_HPUS-1:0][ID_W-1:0]            cmd_id_i,
    input  logic [NUM_HPUS-1:0][CMD_DATA_WIDTH-1:0]  cmd_data_i,
    output logic                                     eng_req_valid_o,
    input  logic                                     eng_req_ready_i,
    output logic [TAG_W-1:0]                         eng_req_tag_o,
    output logic [CMD_DATA_WIDTH-1:0]                eng_req_data_o,
    input  logic                                     eng_resp_valid_i,
    input  logic [TAG_W-1:0]                         eng_resp_tag_i,
    output logic                                     cmd_resp_valid_o,
    output logic [ID_W-1:0]                          cmd_resp_id_o,
    output logic [TAG_W:0]                           num_outstanding_o,
    output logic                                     idle_o,
    output logic                                     resp_err_o
);

    localparam int unsigned HPU_W = (NUM_HPUS > 1) ? $clog2(NUM_HPUS) : 1;

    logic [NUM_OUTSTANDING-1:0]           busy_q, busy_d;
    logic [NUM_OUTSTANDING-1:0][ID_W-1:0] id_q, id_d;
    logic                                 req_valid_q, req_valid_d;
    logic [TAG_W-1:0]                     req_tag_q, req_tag_d;
    logic [CMD_DATA_WIDTH-1:0]            req_data_q, req_data_d;
    logic [HPU_W-1:0]                     rr_ptr_q, rr_ptr_d;
    logic                                 resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]                      resp_id_q, resp_id_d;
    logic                                 err_q, err_d;

    logic             free_found;
    logic [TAG_W-1:0] free_tag;
    logic             any_valid;
    logic [HPU_W-1:0] grant_idx;
    logic [HPU_W-1:0] arb_idx;
    logic             can_load;
    logic             grant;
    logic [TAG_W:0]   busy_cnt;

    // Lowest-index free tag.
    always_comb begin
        free_found = 1'b0;
        free_tag   = '0;
        for (int unsigned i = 0; i < NUM_OUTSTANDING; i++) begin
            if (!busy_q[i] && !free_found) begin
                free_found = 1'b1;
                free_tag   = TAG_W'(i);
            end
        end
    end

    // Round-robin search starting at rr_ptr_q.
    always_comb begin
        any_valid = 1'b0;
        grant_idx = '0;
        arb_idx   = '0;
        for (int unsigned k = 0; k < NUM_HPUS; k++) begin
            arb_idx = HPU_W'((32'(rr_ptr_q) + k) % NUM_HPUS);
            if (cmd_valid_i[arb_idx] && !any_valid) begin
                any_valid = 1'b1;
                grant_idx = arb_idx;
            end
        end
    end

    assign can_load = !req_valid_q || eng_req_ready_i;
    assign grant    = any_valid && free_found && can_load;

    always_comb begin
        cmd_ready_o = '0;
        if (grant) begin
            cmd_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        busy_d       = busy_q;
        id_d         = id_q;
        req_valid_d  = req_valid_q;
        req_tag_d    = req_tag_q;
        req_data_d   = req_data_q;
        rr_ptr_d     = rr_ptr_q;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        err_d        = err_q;

        if (req_valid_q && eng_req_ready_i) begin
            req_valid_d = 1'b0;
        end

        if (grant) begin
            busy_d[free_tag] = 1'b1;
            id_d[free_tag]   = cmd_id_i[grant_idx];
            req_valid_d      = 1'b1;
            req_tag_d        = free_tag;
            req_data_d       = cmd_data_i[grant_idx];
            rr_ptr_d         = (32'(grant_idx) == NUM_HPUS - 1) ? '0 : grant_idx + 1'b1;
        end

        // The freed tag cannot collide with this cycle's allocation: it is still busy here.
        if (eng_resp_valid_i) begin
            if (busy_q[eng_resp_tag_i]) begin
                busy_d[eng_resp_tag_i] = 1'b0;
                resp_valid_d           = 1'b1;
                resp_id_d              = id_q[eng_resp_tag_i];
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q       <= '0;
            id_q         <= '0;
            req_valid_q  <= 1'b0;
            req_tag_q    <= '0;
            req_data_q   <= '0;
            rr_ptr_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            id_q         <= id_d;
            req_valid_q  <= req_valid_d;
            req_tag_q    <= req_tag_d;
            req_data_q   <= req_data_d;
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        busy_cnt = '0;
        for (int unsigned i = 0; i < NUM_OUTSTANDING; i++) begin
            busy_cnt = busy_cnt + (TAG_W+1)'(busy_q[i]);
        end
    end

    assign eng_req_valid_o   = req_valid_q;
    assign eng_req_tag_o     = req_tag_q;
    assign eng_req_data_o    = req_data_q;
    assign cmd_resp_valid_o  = resp_valid_q;
    assign cmd_resp_id_o     = resp_id_q;
    assign num_outstanding_o = busy_cnt;
    assign idle_o            = (busy_q == '0) && !req_valid_q;
    assign resp_err_o        = err_q;

endmodule

// File: tb/tb_pspin_cmd_responder.sv
// Directed bench for pspin_cmd_responder: a per-cycle vector table plus hand-written
// sequences for the full-table, backpressure, error and reset corner cases.
module tb_pspin_cmd_responder;

    localparam int unsigned NH    = 8;
    localparam int unsigned ID_W  = 36;
    localparam int unsigned DW    = 128;
    localparam int unsigned TAG_W = 3;

    logic                     clk = 1'b0;
    logic                     rst_ni;
    logic [NH-1:0]            cmd_valid;
    logic [NH-1:0]            cmd_ready;
    logic [NH-1:0][ID_W-1:0]  cmd_id;
    logic [NH-1:0][DW-1:0]    cmd_data;
    logic                     eng_req_valid;
    logic                     eng_req_ready;
    logic [TAG_W-1:0]         eng_req_tag;
    logic [DW-1:0]            eng_req_data;
    logic                     eng_resp_valid;
    logic [TAG_W-1:0]         eng_resp_tag;
    logic                     cmd_resp_valid;
    logic [ID_W-1:0]          cmd_resp_id;
    logic [TAG_W:0]           num_out;
    logic                     idle;
    logic                     resp_err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pspin_cmd_responder dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .cmd_valid_i       (cmd_valid),
        .cmd_ready_o       (cmd_ready),
        .cmd_id_i          (cmd_id),
        .cmd_data_i        (cmd_data),
        .eng_req_valid_o   (eng_req_valid),
        .eng_req_ready_i   (eng_req_ready),
        .eng_req_tag_o     (eng_req_tag),
        .eng_req_data_o    (eng_req_data),
        .eng_resp_valid_i  (eng_resp_valid),
        .eng_resp_tag_i    (eng_resp_tag),
        .cmd_resp_valid_o  (cmd_resp_valid),
        .cmd_resp_id_o     (cmd_resp_id),
        .num_outstanding_o (num_out),
        .idle_o            (idle),
        .resp_err_o        (resp_err)
    );

    typedef struct {
        logic [7:0]      valid;
        logic            rdy;
        logic            rv;
        logic [2:0]      rtag;
        logic [7:0]      e_ready;
        logic            e_rqv;
        logic [2:0]      e_rqtag;
        logic            e_rspv;
        logic [ID_W-1:0] e_rspid;
        logic [3:0]      e_num;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [ID_W-1:0] id_of(input int h);
        return {16'h0001, 16'(h), 4'(h)};
    endfunction

    function automatic logic [DW-1:0] data_of(input int h);
        return 128'hD000 + 128'(h);
    endfunction

    function automatic vec_t mk(input logic [7:0] v, input logic r, input logic rv,
                                input logic [2:0] rt, input logic [7:0] er, input logic eq,
                                input logic [2:0] et, input logic es, input logic [ID_W-1:0] ei,
                                input logic [3:0] en);
        vec_t x;
        x.valid = v; x.rdy = r; x.rv = rv; x.rtag = rt;
        x.e_ready = er; x.e_rqv = eq; x.e_rqtag = et; x.e_rspv = es; x.e_rspid = ei;
        x.e_num = en;
        return x;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [7:0] v, input logic r, input logic rv, input logic [2:0] rt);
        cmd_valid      = v;
        eng_req_ready  = r;
        eng_resp_valid = rv;
        eng_resp_tag   = rt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(8'h00, 1'b0, 1'b0, 3'd0);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        drive(8'h00, 1'b0, 1'b0, 3'd0);
        for (int h = 0; h < NH; h++) begin
            cmd_id[h]   = id_of(h);
            cmd_data[h] = data_of(h);
        end

        // Round-robin over HPUs 0,2,5, frees, same-cycle alloc/free and a stalled register.
        vecs[0]  = mk(8'h25, 1, 0, 0, 8'h01, 0, 0, 0, '0, 0);
        vecs[1]  = mk(8'h25, 1, 0, 0, 8'h04, 1, 0, 0, '0, 1);
        vecs[2]  = mk(8'h25, 1, 0, 0, 8'h20, 1, 1, 0, '0, 2);
        vecs[3]  = mk(8'h25, 1, 0, 0, 8'h01, 1, 2, 0, '0, 3);
        vecs[4]  = mk(8'h25, 1, 0, 0, 8'h04, 1, 3, 0, '0, 4);
        vecs[5]  = mk(8'h25, 1, 0, 0, 8'h20, 1, 4, 0, '0, 5);
        vecs[6]  = mk(8'h00, 1, 1, 2, 8'h00, 1, 5, 0, '0, 6);
        vecs[7]  = mk(8'h00, 1, 0, 0, 8'h00, 0, 0, 1, id_of(5), 5);
        vecs[8]  = mk(8'h02, 1, 1, 0, 8'h02, 0, 0, 0, '0, 5);
        vecs[9]  = mk(8'h00, 0, 0, 0, 8'h00, 1, 2, 1, id_of(0), 5);
        vecs[10] = mk(8'h08, 0, 0, 0, 8'h00, 1, 2, 0, '0, 5);
        vecs[11] = mk(8'h08, 1, 0, 0, 8'h08, 1, 2, 0, '0, 5);
        vecs[12] = mk(8'h00, 1, 0, 0, 8'h00, 1, 0, 0, '0, 6);
        vecs[13] = mk(8'h00, 1, 0, 0, 8'h00, 0, 0, 0, '0, 6);

        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 128'(cmd_ready), 128'h0);
        chk("rst_rqv", 128'(eng_req_valid), 128'h0);
        chk("rst_rqtag", 128'(eng_req_tag), 128'h0);
        chk("rst_rqdata", eng_req_data, 128'h0);
        chk("rst_rspv", 128'(cmd_resp_valid), 128'h0);
        chk("rst_rspid", 128'(cmd_resp_id), 128'h0);
        chk("rst_num", 128'(num_out), 128'h0);
        chk("rst_idle", 128'(idle), 128'h1);
        chk("rst_err", 128'(resp_err), 128'h0);
        @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].rdy, vecs[i].rv, vecs[i].rtag);
            #1;
            chk($sformatf("v%0d_ready", i), 128'(cmd_ready), 128'(vecs[i].e_ready));
            chk($sformatf("v%0d_rqv", i), 128'(eng_req_valid), 128'(vecs[i].e_rqv));
            if (vecs[i].e_rqv)
                chk($sformatf("v%0d_rqtag", i), 128'(eng_req_tag), 128'(vecs[i].e_rqtag));
            chk($sformatf("v%0d_rspv", i), 128'(cmd_resp_valid), 128'(vecs[i].e_rspv));
            if (vecs[i].e_rspv)
                chk($sformatf("v%0d_rspid", i), 128'(cmd_resp_id), 128'(vecs[i].e_rspid));
            chk($sformatf("v%0d_num", i), 128'(num_out), 128'(vecs[i].e_num));
        end

        // Single command from HPU 3.
        do_reset();
        cmd_id[3]   = {16'd1, 16'd3, 4'd2};
        cmd_data[3] = 128'hA5;
        @(negedge clk); drive(8'h08, 1, 0, 0); #1;
        chk("s_ready", 128'(cmd_ready), 128'h08);
        @(negedge clk); drive(8'h00, 1, 0, 0); #1;
        chk("s_rqv", 128'(eng_req_valid), 128'h1);
        chk("s_rqtag", 128'(eng_req_tag), 128'h0);
        chk("s_rqdata", eng_req_data, 128'hA5);
        chk("s_num1", 128'(num_out), 128'h1);
        chk("s_idle0", 128'(idle), 128'h0);
        @(negedge clk); drive(8'h00, 1, 0, 0); #1;
        chk("s_drained", 128'(eng_req_valid), 128'h0);
        @(negedge clk); drive(8'h00, 1, 1, 0); #1;
        chk("s_rspv_pre", 128'(cmd_resp_valid), 128'h0);
        @(negedge clk); drive(8'h00, 1, 0, 0); #1;
        chk("s_rspv", 128'(cmd_resp_valid), 128'h1);
        chk("s_rspid", 128'(cmd_resp_id), 128'({16'd1, 16'd3, 4'd2}));
        chk("s_num0", 128'(num_out), 128'h0);
        chk("s_idle1", 128'(idle), 128'h1);
        @(negedge clk); #1;
        chk("s_rspv_pulse", 128'(cmd_resp_valid), 128'h0);
        chk("s_rspid_hold", 128'(cmd_resp_id), 128'({16'd1, 16'd3, 4'd2}));
        cmd_id[3]   = id_of(3);
        cmd_data[3] = data_of(3);

        // Fill the table from HPU 0, then free tag 4 while HPU 1 waits.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); drive(8'h01, 1, 0, 0); #1;
            chk($sformatf("f_ready%0d", i), 128'(cmd_ready), 128'h01);
            if (i > 0) chk($sformatf("f_tag%0d", i), 128'(eng_req_tag), 128'(i - 1));
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive(8'h02, 1, 0, 0); #1;
            chk($sformatf("f_full_ready%0d", i), 128'(cmd_ready), 128'h00);
            chk($sformatf("f_full_num%0d", i), 128'(num_out), 128'h8);
        end
        @(negedge clk); drive(8'h02, 1, 1, 3'd4); #1;
        chk("f_m_ready", 128'(cmd_ready), 128'h00);
        @(negedge clk); drive(8'h02, 1, 0, 0); #1;
        chk("f_m1_ready", 128'(cmd_ready), 128'h02);
        chk("f_m1_rspv", 128'(cmd_resp_valid), 128'h1);
        chk("f_m1_rspid", 128'(cmd_resp_id), 128'(id_of(0)));
        chk("f_m1_num", 128'(num_out), 128'h7);
        @(negedge clk); drive(8'h00, 1, 0, 0); #1;
        chk("f_newtag", 128'(eng_req_tag), 128'h4);
        chk("f_newdata", eng_req_data, data_of(1));
        chk("f_num8", 128'(num_out), 128'h8);

        // Engine backpressure with HPUs 1,4,6 valid.
        do_reset();
        @(negedge clk); drive(8'h52, 0, 0, 0); #1;
        chk("b_ready0", 128'(cmd_ready), 128'h02);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk); drive(8'h52, 0, 0, 0); #1;
            chk($sformatf("b_stall_ready%0d", i), 128'(cmd_ready), 128'h00);
            chk($sformatf("b_stall_rqv%0d", i), 128'(eng_req_valid), 128'h1);
            chk($sformatf("b_stall_tag%0d", i), 128'(eng_req_tag), 128'h0);
            chk($sformatf("b_stall_data%0d", i), eng_req_data, data_of(1));
        end
        @(negedge clk); drive(8'h52, 1, 0, 0); #1;
        chk("b_release_ready", 128'(cmd_ready), 128'h10);
        @(negedge clk); drive(8'h00, 1, 0, 0); #1;
        chk("b_next_tag", 128'(eng_req_tag), 128'h1);
        chk("b_next_data", eng_req_data, data_of(4));
        chk("b_num", 128'(num_out), 128'h2);

        // Completion for a free tag.
        @(negedge clk); drive(8'h00, 1, 1, 3'd6); #1;
        chk("e_err_pre", 128'(resp_err), 128'h0);
        @(negedge clk); drive(8'h00, 1, 0, 0); #1;
        chk("e_rspv", 128'(cmd_resp_valid), 128'h0);
        chk("e_err", 128'(resp_err), 128'h1);
        chk("e_num", 128'(num_out), 128'h2);
        repeat (3) @(negedge clk);
        #1;
        chk("e_err_sticky", 128'(resp_err), 128'h1);

        // Reset with four tags busy.
        @(negedge clk); drive(8'h04, 1, 0, 0);
        @(negedge clk); drive(8'h04, 1, 0, 0);
        @(negedge clk); drive(8'h00, 1, 0, 0); #1;
        chk("r_num4", 128'(num_out), 128'h4);
        do_reset();
        #1;
        chk("r_num", 128'(num_out), 128'h0);
        chk("r_idle", 128'(idle), 128'h1);
        chk("r_err", 128'(resp_err), 128'h0);
        @(negedge clk); drive(8'h00, 1, 1, 3'd2); #1;
        chk("r_rspv0", 128'(cmd_resp_valid), 128'h0);
        @(negedge clk); drive(8'h00, 1, 0, 0); #1;
        chk("r_rspv1", 128'(cmd_resp_valid), 128'h0);
        chk("r_num_after", 128'(num_out), 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
